// File: rtl/pipelined_hca_adder.sv
// Pipelined Han-Carlson prefix adder with carry-in and valid/ready flow control.
// Optional signed-overflow output is enabled by defining HCA_OVF_EN.
module pipelined_hca_adder #(
    parameter int WIDTH       = 24,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             cin_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum_o,
    output logic             ovf_o
);

    localparam int LVL  = $clog2(WIDTH) + 1;
    localparam int NLEV = LVL + 2;

    // Level index that register rank k follows (rounded, half up).
    function automatic int rank_pos(input int k);
        return (2 * k * NLEV + PIPE_STAGES) / (2 * PIPE_STAGES) - 1;
    endfunction

    // Rank number placed after prefix level lv, or 0 if none; the last rank is always after the sum level.
    function automatic int rank_at(input int lv);
        int r;
        r = 0;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (rank_pos(k) == lv) r = k;
        end
        return r;
    endfunction

    logic [PIPE_STAGES:1] v_reg;
    logic [PIPE_STAGES:1] ld;
    logic [PIPE_STAGES:1] vin;
    logic                 ld_chain;

    // Load enables ripple back from the output so bubbles collapse.
    always_comb begin
        ld       = '0;
        vin      = '0;
        ld_chain = out_ready;
        for (int k = PIPE_STAGES; k >= 1; k--) begin
            ld[k]    = !v_reg[k] || ld_chain;
            ld_chain = ld[k];
        end
        vin[1] = in_valid;
        for (int k = 2; k <= PIPE_STAGES; k++) begin
            vin[k] = v_reg[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_reg <= '0;
        end else begin
            for (int k = 1; k <= PIPE_STAGES; k++) begin
                if (ld[k]) v_reg[k] <= vin[k];
            end
        end
    end

    assign in_ready  = ld[1];
    assign out_valid = v_reg[PIPE_STAGES];

    for (genvar lv = 0; lv <= LVL; lv++) begin : g_lvl
        localparam int RK = rank_at(lv);
        logic [WIDTH-1:0] g_next, p_next, p0_next;
        logic             cin_next;
        logic [WIDTH-1:0] g_out, p_out, p0_out;
        logic             cin_out;

        if (lv == 0) begin : g_gp
            assign g_next   = x_i & y_i;
            assign p_next   = x_i ^ y_i;
            assign p0_next  = x_i ^ y_i;
            assign cin_next = cin_i;
        end else begin : g_prefix
            // Levels below LVL combine odd bits at doubling spans; level LVL fixes up even bits from their odd neighbour.
            localparam int SPAN = (lv < LVL) ? (1 << (lv - 1)) : 1;
            assign p0_next  = g_lvl[lv-1].p0_out;
            assign cin_next = g_lvl[lv-1].cin_out;
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
                localparam bit COMBINE = (lv < LVL) ? ((gi % 2 == 1) && (gi >= SPAN))
                                                    : ((gi % 2 == 0) && (gi > 0));
                if (COMBINE) begin : g_op
                    assign g_next[gi] = g_lvl[lv-1].g_out[gi]
                                      | (g_lvl[lv-1].p_out[gi] & g_lvl[lv-1].g_out[gi-SPAN]);
                    assign p_next[gi] = g_lvl[lv-1].p_out[gi] & g_lvl[lv-1].p_out[gi-SPAN];
                end else begin : g_pass
                    assign g_next[gi] = g_lvl[lv-1].g_out[gi];
                    assign p_next[gi] = g_lvl[lv-1].p_out[gi];
                end
            end
        end

        if (RK != 0) begin : g_rank
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    g_out   <= '0;
                    p_out   <= '0;
                    p0_out  <= '0;
                    cin_out <= 1'b0;
                end else if (ld[RK] && vin[RK]) begin
                    g_out   <= g_next;
                    p_out   <= p_next;
                    p0_out  <= p0_next;
                    cin_out <= cin_next;
                end
            end
        end else begin : g_thru
            assign g_out   = g_next;
            assign p_out   = p_next;
            assign p0_out  = p0_next;
            assign cin_out = cin_next;
        end
    end

    logic [WIDTH:0] carry;
    logic [WIDTH:0] sum_next;
    logic [WIDTH:0] sum_reg;

    // Group prefixes start at bit 0, so carry-in folds in with a single AND-OR per bit.
    always_comb begin
        carry    = '0;
        carry[0] = g_lvl[LVL].cin_out;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = g_lvl[LVL].g_out[i] | (g_lvl[LVL].p_out[i] & g_lvl[LVL].cin_out);
        end
        sum_next = {carry[WIDTH], g_lvl[LVL].p0_out ^ carry[WIDTH-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_reg <= '0;
        end else if (ld[PIPE_STAGES] && vin[PIPE_STAGES]) begin
            sum_reg <= sum_next;
        end
    end

    assign sum_o = sum_reg;

`ifdef HCA_OVF_EN
    logic ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (ld[PIPE_STAGES] && vin[PIPE_STAGES]) begin
            ovf_reg <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    assign ovf_o = ovf_reg;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_hca_adder.sv
// Scoreboard bench for pipelined_hca_adder: directed vectors, stalls, mid-stream reset, random beats.
module tb_pipelined_hca_adder;

    localparam int W = 24;
    localparam int P = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x_i = '0;
    logic [W-1:0] y_i = '0;
    logic         cin_i = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W:0]   sum_o;
    logic         ovf_o;

    always #5 clk = ~clk;

    pipelined_hca_adder #(.WIDTH(W), .PIPE_STAGES(P)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_i      (x_i),
        .y_i      (y_i),
        .cin_i    (cin_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_o    (sum_o),
        .ovf_o    (ovf_o)
    );

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        logic [W:0]   s;
        logic         o;
    } vec_t;

    typedef struct {
        logic [W:0] sum;
        logic       ovf;
        int         acc_cyc;
        bit         lat;
    } exp_t;

    localparam int NV = 11;
    vec_t tab [NV] = '{
        '{24'hFFFFFF, 24'h000001, 1'b0, 25'h1000000, 1'b0},
        '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 25'h1FFFFFF, 1'b0},
        '{24'h000000, 24'h000000, 1'b0, 25'h0000000, 1'b0},
        '{24'h000000, 24'h000000, 1'b1, 25'h0000001, 1'b0},
        '{24'h7FFFFF, 24'h000001, 1'b0, 25'h0800000, 1'b1},
        '{24'h800000, 24'h800000, 1'b0, 25'h1000000, 1'b1},
        '{24'h123456, 24'h654321, 1'b0, 25'h0777777, 1'b0},
        '{24'hAAAAAA, 24'h555555, 1'b1, 25'h1000000, 1'b0},
        '{24'h800000, 24'hFFFFFF, 1'b0, 25'h17FFFFF, 1'b1},
        '{24'h0F0F0F, 24'hF0F0F0, 1'b0, 25'h0FFFFFF, 1'b0},
        '{24'h7FFFFF, 24'h7FFFFF, 1'b1, 25'h0FFFFFF, 1'b1}
    };

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_beats  = 0;
    bit   rand_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic ovf_sel(input logic o);
`ifdef HCA_OVF_EN
        return o;
`else
        return 1'b0;
`endif
    endfunction

    // Offer one beat from posedge+1; push the expectation at the negedge where the handshake is seen.
    task automatic send(input vec_t v, input bit lat, input bit nostall);
        int   n;
        exp_t e;
        in_valid = 1'b1;
        x_i      = v.x;
        y_i      = v.y;
        cin_i    = v.c;
        n        = 0;
        forever begin
            @(negedge clk);
            if (nostall && n == 0) chk("in_ready_nostall", in_ready, 1);
            if (in_ready) break;
            n++;
            if (n >= 100) begin
                n_checks++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", n);
                break;
            end
        end
        if (in_ready) begin
            e.sum     = v.s;
            e.ovf     = ovf_sel(v.o);
            e.acc_cyc = cyc;
            e.lat     = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
            sb.delete();
        end
        #1;
        chk("no_extra_output", out_valid, 0);
    endtask

    // Monitor: pops and compares on every output handshake, and checks output stability under stall.
    exp_t       mon_e;
    logic       hold = 1'b0;
    logic [W:0] hold_sum;
    logic       hold_ovf;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("sum_hold", sum_o, hold_sum);
                    chk("ovf_hold", ovf_o, hold_ovf);
                    chk("valid_hold", out_valid, 1);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: got sum_o 0x%0h, required no output", sum_o);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("sum", sum_o, mon_e.sum);
                        chk("ovf", ovf_o, mon_e.ovf);
                        if (mon_e.lat) chk("latency", cyc - mon_e.acc_cyc, P);
                        $display("beat %0d: sum_o=0x%07h ovf_o=%0b", n_beats, sum_o, ovf_o);
                        n_beats++;
                    end
                end
                hold     = out_valid && !out_ready;
                hold_sum = sum_o;
                hold_ovf = ovf_o;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) out_ready = 1'($urandom_range(1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum_o, 0);
        chk("rst_ovf", ovf_o, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Directed vectors back to back with latency checks.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) send(tab[i], 1'b1, 1'b1);
        drain();

        // Fill the pipe with the consumer stalled, then release with a simultaneous accept.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(tab[0], 1'b0, 1'b1);
        send(tab[1], 1'b0, 1'b1);
        in_valid = 1'b1;
        x_i      = tab[2].x;
        y_i      = tab[2].y;
        cin_i    = tab[2].c;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_sum", sum_o, tab[0].s);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(tab[2], 1'b0, 1'b1);
        drain();

        // Reset with two beats in flight; they are discarded.
        send(tab[3], 1'b0, 1'b1);
        send(tab[4], 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum_o, 0);
        chk("midrst_ovf", ovf_o, 0);
        sb.delete();
        #6 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_no_output", out_valid, 0);
        send(tab[5], 1'b1, 1'b1);
        drain();

        // Random beats back to back with the consumer always ready.
        for (int i = 0; i < 100; i++) begin
            v.x = W'($urandom());
            v.y = W'($urandom());
            v.c = 1'($urandom_range(1));
            v.s = {1'b0, v.x} + {1'b0, v.y} + {{W{1'b0}}, v.c};
            v.o = (v.x[W-1] == v.y[W-1]) && (v.s[W-1] != v.x[W-1]);
            send(v, 1'b1, 1'b1);
        end
        drain();

        // Random beats with stalls on both sides.
        rand_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            v.x = W'($urandom());
            v.y = W'($urandom());
            v.c = 1'($urandom_range(1));
            v.s = {1'b0, v.x} + {1'b0, v.y} + {{W{1'b0}}, v.c};
            v.o = (v.x[W-1] == v.y[W-1]) && (v.s[W-1] != v.x[W-1]);
            send(v, 1'b0, 1'b0);
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_mode = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
